addr_gen_unit: RTL

ADDR_GEN_UNIT -- requirements
Module: addr_gen_unit

---
 rtl/agu_pkg.sv | 35 +++
 rtl/agu_out_reg.sv | 36 +++
 rtl/addr_gen_unit.sv | 76 +++++++
 3 files changed

// File: rtl/agu_pkg.sv
// Shared size encodings and byte-lane/alignment helpers for the address generation unit.
package agu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Contiguous lane mask for the access, shifted to its byte offset; callers truncate to their lane count.
  function automatic logic [7:0] byte_mask(input size_e sz, input logic [2:0] lsb);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << lsb;
  endfunction

  // A double is never legal on a 32-bit datapath, whatever its address.
  function automatic logic is_misaligned(input size_e sz, input logic [2:0] lsb, input logic xlen64);
    logic r;
    case (sz)
      SZ_B:    r = 1'b0;
      SZ_H:    r = lsb[0];
      SZ_W:    r = |lsb[1:0];
      default: r = !xlen64 || (|lsb);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/agu_out_reg.sv
// Single-entry valid/ready output register; full throughput via combinational in_ready.
module agu_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q
);

  logic         r_valid;
  logic [W-1:0] r_q;
  logic         w_load;

  assign in_ready  = !r_valid || out_ready;
  assign w_load    = in_valid && in_ready;
  assign out_valid = r_valid;
  assign q         = r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_q     <= d;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/addr_gen_unit.sv
// Load/store effective address, byte lanes and alignment check, one registered stage.
// Alignment checking and the misalign counter exist only with ADDR_GEN_MISALIGN_CHECK_EN defined.
module addr_gen_unit
  import agu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   base,
  input  logic [XLEN-1:0]   offset,
  input  logic [1:0]        size,
  input  logic              is_store,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   addr,
  output logic [XLEN/8-1:0] byte_en,
  output logic              misaligned,
  output logic              is_store_o,
  output logic [CNT_W-1:0]  misalign_cnt
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int PW = XLEN + NB + 2;

  logic [XLEN-1:0] w_addr;
  logic [NB-1:0]   w_be;
  logic            w_mis;
  logic            w_acc;
  logic [PW-1:0]   w_d;
  logic [PW-1:0]   w_q;

  assign w_addr = base + offset;
  assign w_acc  = in_valid && in_ready;

`ifdef ADDR_GEN_MISALIGN_CHECK_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_mis = is_misaligned(size_e'(size), w_addr[2:0], XLEN == 64);
  assign w_be  = w_mis ? '0 : NB'(byte_mask(size_e'(size), 3'(w_addr[OW-1:0])));

  // Counts at acceptance so the count lines up with the result it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_acc && w_mis && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign misalign_cnt = r_cnt;
`else
  assign w_mis        = 1'b0;
  assign w_be         = NB'(byte_mask(size_e'(size), 3'(w_addr[OW-1:0])));
  assign misalign_cnt = '0;
`endif

  assign w_d = {w_addr, w_be, w_mis, is_store};

  agu_out_reg #(.W(PW)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (w_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (w_q)
  );

  assign {addr, byte_en, misaligned, is_store_o} = w_q;

endmodule
